inv_sqrt_sched: RTL



---
 rtl/inv_sqrt_sched_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/inv_sqrt_sched.sv | 122 ++++++++++++
 3 files changed

// File: rtl/inv_sqrt_sched_pkg.sv
// rtl/inv_sqrt_sched_pkg.sv - shared types and constants for the inverse-sqrt scheduler
package inv_sqrt_sched_pkg;

  localparam int FP16_W = 16;
  localparam int OFUF_W = 2;

  localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SETTLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter; search starts one past ptr
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    logic [IDX_W-1:0] c;
    logic             found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = '0;
    // k = N wraps back to ptr itself, so the last winner is lowest priority.
    for (int k = 1; k <= N; k++) begin
      c = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = c;
      end
    end
  end

endmodule

// File: rtl/inv_sqrt_sched.sv
// rtl/inv_sqrt_sched.sv - shares one iterative FP16 inverse-sqrt unit between NUM_REQ requesters
module inv_sqrt_sched
  import inv_sqrt_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [FP16_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [FP16_W-1:0]         resp_data,
  output logic [OFUF_W-1:0]         resp_ofuf,
  output logic                      resp_err,
  output logic                      busy,
  output logic [FP16_W-1:0]         unit_xin,
  output logic                      unit_start,
  input  logic                      unit_done,
  input  logic [FP16_W-1:0]         unit_result,
  input  logic [OFUF_W-1:0]         unit_ofuf
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic [FP16_W-1:0]  req_word [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_word[i] = req_data[i*FP16_W +: FP16_W];
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  // reset_n in the gate keeps req_ready low while reset is held, even with requests pending.
  assign req_ready = (state == IDLE && reset_n) ? grant : '0;
  assign accept    = |req_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= ID_W'(NUM_REQ - 1);
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_ofuf  <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      unit_xin   <= '0;
      unit_start <= 1'b0;
    end else begin
      unit_start <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            unit_xin   <= req_word[grant_idx];
            resp_id    <= grant_idx;
            ptr        <= grant_idx;
            unit_start <= 1'b1;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          state <= SETTLE;
        end
        SETTLE: begin
          // unit_done may still be high from the previous operation here.
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (unit_done) begin
            resp_data  <= unit_result;
            resp_ofuf  <= unit_ofuf;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (cnt == CNT_LAST) begin
            resp_data  <= FP16_QNAN;
            resp_ofuf  <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
